axis_perf_monitor_mc: RTL and testbench

//  Passive multi-channel AXI-Stream performance monitor: the generalised successor of the single-link

---
 rtl/axis_perf_pkg.sv | 31 +++
 rtl/axis_perf_chan.sv | 175 +++++++++++++++++
 rtl/axis_perf_monitor_mc.sv | 106 ++++++++++
 tb/tb_axis_perf_monitor_mc.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_perf_pkg.sv
// Shared types and helpers for the multi-channel AXI-Stream performance monitor.
package axis_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int CNT_W_DEF  = 32;
  localparam int KEEP_W_MAX = 64;

  // Saturating add on a 64-bit datapath; bit 64 flags that the true sum exceeded max.
  function automatic logic [64:0] sat_inc(input logic [63:0] val,
                                          input logic [63:0] inc,
                                          input logic [63:0] max);
    logic [64:0] sum;
    sum = {1'b0, val} + {1'b0, inc};
    if (sum > {1'b0, max}) begin
      return {1'b1, max};
    end
    return sum;
  endfunction

  // True when the set bits form one run starting at bit 0 (zero counts as contiguous).
  function automatic logic keep_contiguous(input logic [63:0] keep);
    return (keep & (keep + 64'd1)) == 64'd0;
  endfunction

endpackage

// File: rtl/axis_perf_chan.sv
// One monitored link: window FSM, six saturating statistic counters and sticky overflow.
// state | meaning
// IDLE  | cleared, not measuring
// ARMED | target latched, waiting for the first handshaked beat
// RUN   | window open, every cycle counted
// DONE  | window closed, counters frozen until clear or start
// Supports KEEP_W up to 64 and CNT_W up to 63.
module axis_perf_chan
  import axis_perf_pkg::*;
#(
  parameter int KEEP_W = 64,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tvalid,
  input  logic              i_tready,
  input  logic              i_tlast,
  input  logic [KEEP_W-1:0] i_tkeep,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_clear,
  input  logic [CNT_W-1:0]  i_cfg_pkt_target,
  output logic [CNT_W-1:0]  o_cycles,
  output logic [CNT_W-1:0]  o_beats,
  output logic [CNT_W-1:0]  o_pkts,
  output logic [CNT_W-1:0]  o_bytes,
  output logic [CNT_W-1:0]  o_stalls,
  output logic [CNT_W-1:0]  o_err_beats,
  output logic [1:0]        o_state,
  output logic              o_ovf,
  output logic              o_active,
  output logic              o_done
);

  localparam int          POP_W = $clog2(KEEP_W + 1);
  localparam logic [63:0] C_MAX = (64'd1 << CNT_W) - 64'd1;

  state_e            r_state, w_state_nx;
  logic [CNT_W-1:0]  r_cycles, r_beats, r_pkts, r_bytes, r_stalls, r_err, r_target;
  logic [CNT_W-1:0]  w_cycles_nx, w_beats_nx, w_pkts_nx, w_bytes_nx, w_stalls_nx, w_err_nx;
  logic [CNT_W-1:0]  w_target_nx;
  logic              r_ovf, w_ovf_nx, r_active, r_done;

  logic              w_beat, w_stall, w_mal, w_in_run, w_acc, w_hit_target, w_sat;
  logic [POP_W-1:0]  w_pop;
  logic [64:0]       w_cyc_s, w_beat_s, w_pkt_s, w_byte_s, w_stall_s, w_err_s;

  // Combinational byte count of the current beat's tkeep.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      w_pop = w_pop + POP_W'(i_tkeep[i]);
    end
  end

  assign w_beat   = i_tvalid & i_tready;
  assign w_stall  = i_tvalid & ~i_tready;
  assign w_mal    = (i_tkeep == '0) | ~keep_contiguous(64'(i_tkeep)) |
                    (~i_tlast & (i_tkeep != '1));
  assign w_in_run = (r_state == ST_RUN);
  // The first beat in ARMED opens the window, so it accumulates onto zero.
  assign w_acc    = ((r_state == ST_ARMED) & w_beat) | w_in_run;

  assign w_cyc_s   = sat_inc(w_in_run ? 64'(r_cycles) : 64'd0, 64'd1, C_MAX);
  assign w_beat_s  = sat_inc(w_in_run ? 64'(r_beats)  : 64'd0, 64'(w_beat), C_MAX);
  assign w_pkt_s   = sat_inc(w_in_run ? 64'(r_pkts)   : 64'd0, 64'(w_beat & i_tlast), C_MAX);
  assign w_byte_s  = sat_inc(w_in_run ? 64'(r_bytes)  : 64'd0, w_beat ? 64'(w_pop) : 64'd0, C_MAX);
  assign w_stall_s = sat_inc(w_in_run ? 64'(r_stalls) : 64'd0, 64'(w_stall), C_MAX);
  assign w_err_s   = sat_inc(w_in_run ? 64'(r_err)    : 64'd0, 64'(w_beat & w_mal), C_MAX);

  // Upper bits are zero unless a counter clamped, so OR-ing them flags saturation.
  assign w_sat = |{w_cyc_s[64:CNT_W], w_beat_s[64:CNT_W], w_pkt_s[64:CNT_W],
                   w_byte_s[64:CNT_W], w_stall_s[64:CNT_W], w_err_s[64:CNT_W]};

  assign w_hit_target = w_beat & i_tlast & (r_target != '0) &
                        (w_pkt_s[CNT_W-1:0] == r_target);

  // Next-state and counter update; clear dominates start and stop.
  always_comb begin
    w_state_nx  = r_state;
    w_cycles_nx = r_cycles;
    w_beats_nx  = r_beats;
    w_pkts_nx   = r_pkts;
    w_bytes_nx  = r_bytes;
    w_stalls_nx = r_stalls;
    w_err_nx    = r_err;
    w_target_nx = r_target;
    w_ovf_nx    = r_ovf;
    if (i_clear) begin
      w_state_nx  = ST_IDLE;
      w_cycles_nx = '0;
      w_beats_nx  = '0;
      w_pkts_nx   = '0;
      w_bytes_nx  = '0;
      w_stalls_nx = '0;
      w_err_nx    = '0;
      w_ovf_nx    = 1'b0;
    end else if (w_acc) begin
      w_cycles_nx = w_cyc_s[CNT_W-1:0];
      w_beats_nx  = w_beat_s[CNT_W-1:0];
      w_pkts_nx   = w_pkt_s[CNT_W-1:0];
      w_bytes_nx  = w_byte_s[CNT_W-1:0];
      w_stalls_nx = w_stall_s[CNT_W-1:0];
      w_err_nx    = w_err_s[CNT_W-1:0];
      w_ovf_nx    = r_ovf | w_sat;
      w_state_nx  = (w_hit_target | i_stop) ? ST_DONE : ST_RUN;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            w_state_nx  = ST_ARMED;
            w_cycles_nx = '0;
            w_beats_nx  = '0;
            w_pkts_nx   = '0;
            w_bytes_nx  = '0;
            w_stalls_nx = '0;
            w_err_nx    = '0;
            w_ovf_nx    = 1'b0;
            w_target_nx = i_cfg_pkt_target;
          end
        end
        ST_ARMED: begin
          if (i_stop) begin
            w_state_nx = ST_DONE;
          end
        end
        default: begin
          w_state_nx = r_state;
        end
      endcase
    end
  end

  // State, counters and the registered active/done decode share one register stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_cycles <= '0;
      r_beats  <= '0;
      r_pkts   <= '0;
      r_bytes  <= '0;
      r_stalls <= '0;
      r_err    <= '0;
      r_target <= '0;
      r_ovf    <= 1'b0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cycles <= w_cycles_nx;
      r_beats  <= w_beats_nx;
      r_pkts   <= w_pkts_nx;
      r_bytes  <= w_bytes_nx;
      r_stalls <= w_stalls_nx;
      r_err    <= w_err_nx;
      r_target <= w_target_nx;
      r_ovf    <= w_ovf_nx;
      r_active <= (w_state_nx == ST_ARMED) | (w_state_nx == ST_RUN);
      r_done   <= (w_state_nx == ST_DONE);
    end
  end

  assign o_cycles    = r_cycles;
  assign o_beats     = r_beats;
  assign o_pkts      = r_pkts;
  assign o_bytes     = r_bytes;
  assign o_stalls    = r_stalls;
  assign o_err_beats = r_err;
  assign o_state     = r_state;
  assign o_ovf       = r_ovf;
  assign o_active    = r_active;
  assign o_done      = r_done;

endmodule

// File: rtl/axis_perf_monitor_mc.sv
// Passive multi-channel AXI-Stream performance monitor with a registered channel-select readout.
module axis_perf_monitor_mc
  import axis_perf_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int KEEP_W = 64,
  parameter  int CNT_W  = CNT_W_DEF,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_CH-1:0]        mon_tvalid,
  input  logic [NUM_CH-1:0]        mon_tready,
  input  logic [NUM_CH-1:0]        mon_tlast,
  input  logic [NUM_CH*KEEP_W-1:0] mon_tkeep,
  input  logic [NUM_CH-1:0]        ctrl_start,
  input  logic [NUM_CH-1:0]        ctrl_stop,
  input  logic [NUM_CH-1:0]        ctrl_clear,
  input  logic [CNT_W-1:0]         cfg_pkt_target,
  input  logic [SEL_W-1:0]         rd_ch_sel,
  output logic [CNT_W-1:0]         stat_cycles,
  output logic [CNT_W-1:0]         stat_beats,
  output logic [CNT_W-1:0]         stat_pkts,
  output logic [CNT_W-1:0]         stat_bytes,
  output logic [CNT_W-1:0]         stat_stalls,
  output logic [CNT_W-1:0]         stat_err_beats,
  output logic [1:0]               stat_state,
  output logic                     stat_ovf,
  output logic [NUM_CH-1:0]        ch_active,
  output logic [NUM_CH-1:0]        ch_done
);

  logic [CNT_W-1:0] w_cycles [NUM_CH];
  logic [CNT_W-1:0] w_beats  [NUM_CH];
  logic [CNT_W-1:0] w_pkts   [NUM_CH];
  logic [CNT_W-1:0] w_bytes  [NUM_CH];
  logic [CNT_W-1:0] w_stalls [NUM_CH];
  logic [CNT_W-1:0] w_err    [NUM_CH];
  logic [1:0]       w_state  [NUM_CH];
  logic             w_ovf    [NUM_CH];
  logic             w_sel_ok;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    axis_perf_chan #(
      .KEEP_W (KEEP_W),
      .CNT_W  (CNT_W)
    ) u_chan (
      .i_clk            (CLK),
      .i_rst            (RST),
      .i_tvalid         (mon_tvalid[g]),
      .i_tready         (mon_tready[g]),
      .i_tlast          (mon_tlast[g]),
      .i_tkeep          (mon_tkeep[g*KEEP_W +: KEEP_W]),
      .i_start          (ctrl_start[g]),
      .i_stop           (ctrl_stop[g]),
      .i_clear          (ctrl_clear[g]),
      .i_cfg_pkt_target (cfg_pkt_target),
      .o_cycles         (w_cycles[g]),
      .o_beats          (w_beats[g]),
      .o_pkts           (w_pkts[g]),
      .o_bytes          (w_bytes[g]),
      .o_stalls         (w_stalls[g]),
      .o_err_beats      (w_err[g]),
      .o_state          (w_state[g]),
      .o_ovf            (w_ovf[g]),
      .o_active         (ch_active[g]),
      .o_done           (ch_done[g])
    );
  end

  // A select beyond the last channel reads as zero.
  assign w_sel_ok = int'(rd_ch_sel) < NUM_CH;

  // Registered readout mux of the selected channel.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_cycles    <= '0;
      stat_beats     <= '0;
      stat_pkts      <= '0;
      stat_bytes     <= '0;
      stat_stalls    <= '0;
      stat_err_beats <= '0;
      stat_state     <= '0;
      stat_ovf       <= 1'b0;
    end else if (w_sel_ok) begin
      stat_cycles    <= w_cycles[rd_ch_sel];
      stat_beats     <= w_beats[rd_ch_sel];
      stat_pkts      <= w_pkts[rd_ch_sel];
      stat_bytes     <= w_bytes[rd_ch_sel];
      stat_stalls    <= w_stalls[rd_ch_sel];
      stat_err_beats <= w_err[rd_ch_sel];
      stat_state     <= w_state[rd_ch_sel];
      stat_ovf       <= w_ovf[rd_ch_sel];
    end else begin
      stat_cycles    <= '0;
      stat_beats     <= '0;
      stat_pkts      <= '0;
      stat_bytes     <= '0;
      stat_stalls    <= '0;
      stat_err_beats <= '0;
      stat_state     <= '0;
      stat_ovf       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_perf_monitor_mc.sv
module tb_axis_perf_monitor_mc;

  localparam int NA = 4, KA = 64, CA = 32;
  localparam int NB = 2, KB = 8,  CB = 8;
  localparam int L  = 40;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Wide instance (XDMA-like)
  logic [NA-1:0]    a_tvalid, a_tready, a_tlast, a_start, a_stop, a_clear;
  logic [NA*KA-1:0] a_tkeep;
  logic [CA-1:0]    a_target;
  logic [1:0]       a_sel;
  logic [CA-1:0]    a_cyc, a_beats, a_pkts, a_bytes, a_stalls, a_err;
  logic [1:0]       a_state;
  logic             a_ovf;
  logic [NA-1:0]    a_active, a_done;

  // Narrow-counter instance for saturation
  logic [NB-1:0]    b_tvalid, b_tready, b_tlast, b_start, b_stop, b_clear;
  logic [NB*KB-1:0] b_tkeep;
  logic [CB-1:0]    b_target;
  logic [0:0]       b_sel;
  logic [CB-1:0]    b_cyc, b_beats, b_pkts, b_bytes, b_stalls, b_err;
  logic [1:0]       b_state;
  logic             b_ovf;
  logic [NB-1:0]    b_active, b_done;

  axis_perf_monitor_mc #(.NUM_CH(NA), .KEEP_W(KA), .CNT_W(CA)) dut_a (
    .CLK(clk), .RST(rst), .mon_tvalid(a_tvalid), .mon_tready(a_tready), .mon_tlast(a_tlast),
    .mon_tkeep(a_tkeep), .ctrl_start(a_start), .ctrl_stop(a_stop), .ctrl_clear(a_clear),
    .cfg_pkt_target(a_target), .rd_ch_sel(a_sel), .stat_cycles(a_cyc), .stat_beats(a_beats),
    .stat_pkts(a_pkts), .stat_bytes(a_bytes), .stat_stalls(a_stalls), .stat_err_beats(a_err),
    .stat_state(a_state), .stat_ovf(a_ovf), .ch_active(a_active), .ch_done(a_done));

  axis_perf_monitor_mc #(.NUM_CH(NB), .KEEP_W(KB), .CNT_W(CB)) dut_b (
    .CLK(clk), .RST(rst), .mon_tvalid(b_tvalid), .mon_tready(b_tready), .mon_tlast(b_tlast),
    .mon_tkeep(b_tkeep), .ctrl_start(b_start), .ctrl_stop(b_stop), .ctrl_clear(b_clear),
    .cfg_pkt_target(b_target), .rd_ch_sel(b_sel), .stat_cycles(b_cyc), .stat_beats(b_beats),
    .stat_pkts(b_pkts), .stat_bytes(b_bytes), .stat_stalls(b_stalls), .stat_err_beats(b_err),
    .stat_state(b_state), .stat_ovf(b_ovf), .ch_active(b_active), .ch_done(b_done));

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [63:0] keep;
    bit          last;
    int          bytes;
    int          err;
  } vec_t;
  vec_t tbl[8];

  bit          tv[NA][L], tr[NA][L], tl[NA][L];
  logic [63:0] tk[NA][L];
  int          tg[NA], sp[NA];
  longint      m_cyc, m_beats, m_pkts, m_bytes, m_stalls, m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drv(input int c, input bit v, input bit r, input bit l, input logic [63:0] k);
    a_tvalid[c] = v;
    a_tready[c] = r;
    a_tlast[c]  = l;
    a_tkeep[c*KA +: KA] = k;
  endtask

  task automatic idle_all();
    a_tvalid = '0; a_tready = '0; a_tlast = '0; a_tkeep = '0;
    a_start = '0; a_stop = '0; a_clear = '0;
    b_tvalid = '0; b_tready = '0; b_tlast = '0; b_tkeep = '0;
    b_start = '0; b_stop = '0; b_clear = '0;
  endtask

  task automatic check_a(input string tag, input int c, input longint cyc, input longint bt,
                         input longint pk, input longint by, input longint st, input longint er,
                         input int stt, input int ov);
    a_sel = 2'(c);
    tick();
    if (cyc >= 0) chk({tag, " cycles"}, 64'(a_cyc), 64'(cyc));
    chk({tag, " beats"},  64'(a_beats),  64'(bt));
    chk({tag, " pkts"},   64'(a_pkts),   64'(pk));
    chk({tag, " bytes"},  64'(a_bytes),  64'(by));
    chk({tag, " stalls"}, 64'(a_stalls), 64'(st));
    chk({tag, " err"},    64'(a_err),    64'(er));
    chk({tag, " state"},  64'(a_state),  64'(stt));
    chk({tag, " ovf"},    64'(a_ovf),    64'(ov));
  endtask

  task automatic check_b(input string tag, input longint v, input int stt, input int ov);
    b_sel = 1'b0;
    tick();
    chk({tag, " cycles"}, 64'(b_cyc),    64'(v));
    chk({tag, " beats"},  64'(b_beats),  64'(v));
    chk({tag, " pkts"},   64'(b_pkts),   64'(v));
    chk({tag, " bytes"},  64'(b_bytes),  64'(v));
    chk({tag, " stalls"}, 64'(b_stalls), 64'd0);
    chk({tag, " err"},    64'(b_err),    64'd0);
    chk({tag, " state"},  64'(b_state),  64'(stt));
    chk({tag, " ovf"},    64'(b_ovf),    64'(ov));
  endtask

  function automatic bit ref_malformed(input logic [63:0] k, input bit last);
    int n;
    logic [63:0] mask;
    n = $countones(k);
    mask = (n == 64) ? ONES : ((64'd1 << n) - 64'd1);
    return (n == 0) || (k != mask) || (!last && n != 64);
  endfunction

  // Window = first handshake through the target-reaching beat or the stop cycle, whichever is first.
  task automatic model(input int c);
    int f, e, pk;
    m_cyc = 0; m_beats = 0; m_pkts = 0; m_bytes = 0; m_stalls = 0; m_err = 0;
    f = -1;
    for (int i = 0; i <= sp[c]; i++) begin
      if (tv[c][i] && tr[c][i]) begin f = i; break; end
    end
    if (f < 0) return;
    e = sp[c];
    pk = 0;
    for (int i = f; i <= sp[c]; i++) begin
      if (tv[c][i] && tr[c][i] && tl[c][i]) pk++;
      if (tg[c] != 0 && pk == tg[c]) begin e = i; break; end
    end
    m_cyc = e - f + 1;
    for (int i = f; i <= e; i++) begin
      if (tv[c][i] && tr[c][i]) begin
        m_beats++;
        m_bytes += $countones(tk[c][i]);
        if (tl[c][i]) m_pkts++;
        if (ref_malformed(tk[c][i], tl[c][i])) m_err++;
      end else if (tv[c][i]) begin
        m_stalls++;
      end
    end
  endtask

  task automatic gen_traffic();
    for (int c = 0; c < NA; c++) begin
      sp[c] = int'($urandom_range(20, L - 1));
      for (int i = 0; i < L; i++) begin
        int kind;
        tv[c][i] = $urandom_range(0, 3) != 0;
        tr[c][i] = $urandom_range(0, 3) != 0;
        tl[c][i] = $urandom_range(0, 3) == 0;
        kind = int'($urandom_range(0, 5));
        case (kind)
          0, 1, 2: tk[c][i] = ONES;
          3:       tk[c][i] = (64'd1 << $urandom_range(1, 63)) - 64'd1;
          4:       tk[c][i] = 64'd0;
          default: tk[c][i] = {$urandom, $urandom};
        endcase
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{keep: ONES,                   last: 1'b0, bytes: 64, err: 0};
    tbl[1] = '{keep: 64'hFF,                 last: 1'b0, bytes: 8,  err: 1};
    tbl[2] = '{keep: 64'h05,                 last: 1'b1, bytes: 2,  err: 1};
    tbl[3] = '{keep: 64'h0F,                 last: 1'b1, bytes: 4,  err: 0};
    tbl[4] = '{keep: 64'h0,                  last: 1'b1, bytes: 0,  err: 1};
    tbl[5] = '{keep: 64'hFFFF_FFFF_FFFF_FFFE, last: 1'b1, bytes: 63, err: 1};
    tbl[6] = '{keep: ONES,                   last: 1'b1, bytes: 64, err: 0};
    tbl[7] = '{keep: 64'h1,                  last: 1'b1, bytes: 1,  err: 0};

    rst = 1'b1;
    idle_all();
    a_target = '0; a_sel = '0; b_target = '0; b_sel = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check_a("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset active", 64'(a_active), 64'd0);
    chk("reset done",   64'(a_done),   64'd0);
    check_b("reset b", 0, 0, 0);

    // Test 1: ch0, target 4, 4 packets of 3 full beats
    a_target = 32'd4;
    a_start[0] = 1'b1; tick(); a_start[0] = 1'b0;
    chk("t1 active after start", 64'(a_active[0]), 64'd1);
    for (int i = 0; i < 12; i++) begin
      a_drv(0, 1, 1, (i % 3) == 2, ONES);
      tick();
      if (i == 10) chk("t1 done before 12th", 64'(a_done[0]), 64'd0);
    end
    chk("t1 done after 12th", 64'(a_done[0]), 64'd1);
    chk("t1 inactive",        64'(a_active[0]), 64'd0);
    tick(); tick();
    a_drv(0, 0, 0, 0, 64'd0);
    check_a("t1", 0, 12, 12, 4, 768, 0, 0, 3, 0);

    // Test 2: ch1, run-until-stop with a two-cycle stall
    a_target = 32'd0;
    a_start[1] = 1'b1; tick(); a_start[1] = 1'b0;
    a_drv(1, 1, 0, 0, ONES); tick();
    a_drv(1, 1, 1, 0, ONES); tick();
    a_drv(1, 1, 1, 0, ONES); tick();
    a_drv(1, 1, 0, 0, ONES); tick();
    a_drv(1, 1, 0, 0, ONES); tick();
    a_drv(1, 1, 1, 0, ONES); tick();
    a_drv(1, 1, 1, 0, ONES); tick();
    a_drv(1, 1, 1, 1, ONES); tick();
    a_drv(1, 0, 0, 0, 64'd0); tick();
    chk("t2 active before stop", 64'(a_active[1]), 64'd1);
    a_stop[1] = 1'b1; tick(); a_stop[1] = 1'b0;
    chk("t2 done after stop",    64'(a_done[1]), 64'd1);
    chk("t2 inactive",           64'(a_active[1]), 64'd0);
    check_a("t2", 1, 9, 5, 1, 320, 2, 0, 3, 0);

    // Test 3: tkeep classification table on ch2
    a_sel = 2'd2;
    a_start[2] = 1'b1; tick(); a_start[2] = 1'b0;
    begin
      int cb, ce;
      cb = 0; ce = 0;
      for (int i = 0; i < 8; i++) begin
        a_drv(2, 1, 1, tbl[i].last, tbl[i].keep); tick();
        a_drv(2, 0, 0, 0, 64'd0); tick();
        cb += tbl[i].bytes;
        ce += tbl[i].err;
        chk($sformatf("t3 vec%0d bytes", i), 64'(a_bytes), 64'(cb));
        chk($sformatf("t3 vec%0d err", i),   64'(a_err),   64'(ce));
        chk($sformatf("t3 vec%0d beats", i), 64'(a_beats), 64'(i + 1));
      end
    end
    a_stop[2] = 1'b1; tick(); a_stop[2] = 1'b0;

    // Test 5: start ignored in RUN; clear+start -> IDLE; stop in ARMED -> DONE with zero counts
    a_start[3] = 1'b1; tick(); a_start[3] = 1'b0;
    a_drv(3, 1, 1, 0, ONES); tick(); tick(); tick();
    a_start[3] = 1'b1; tick(); a_start[3] = 1'b0;
    a_drv(3, 0, 0, 0, 64'd0);
    check_a("t5 run", 3, -1, 4, 0, 256, 0, 0, 2, 0);
    a_clear[3] = 1'b1; a_start[3] = 1'b1; tick(); a_clear[3] = 1'b0; a_start[3] = 1'b0;
    chk("t5 clear active", 64'(a_active[3]), 64'd0);
    check_a("t5 clear", 3, 0, 0, 0, 0, 0, 0, 0, 0);
    a_start[3] = 1'b1; tick(); a_start[3] = 1'b0;
    a_stop[3] = 1'b1; tick(); a_stop[3] = 1'b0;
    chk("t5 armed stop done", 64'(a_done[3]), 64'd1);
    check_a("t5 armed stop", 3, 0, 0, 0, 0, 0, 0, 3, 0);

    // Test 4: 8-bit counters saturate
    b_target = 8'd0;
    b_sel = 1'b0;
    b_start[0] = 1'b1; tick(); b_start[0] = 1'b0;
    for (int i = 0; i < 300; i++) begin
      b_tvalid[0] = 1'b1; b_tready[0] = 1'b1; b_tlast[0] = 1'b1; b_tkeep[7:0] = 8'h01;
      tick();
      if (i == 255) chk("t4 beats at 255", 64'(b_beats), 64'd255);
      if (i == 256) chk("t4 beats past 256", 64'(b_beats), 64'd255);
    end
    b_tvalid[0] = 1'b0; b_tready[0] = 1'b0; b_tlast[0] = 1'b0; b_tkeep = '0;
    b_stop[0] = 1'b1; tick(); b_stop[0] = 1'b0;
    check_b("t4 sat", 255, 3, 1);
    b_clear[0] = 1'b1; tick(); b_clear[0] = 1'b0;
    check_b("t4 clear", 0, 0, 0);

    // Test 6: randomized concurrent windows against the window model
    for (int it = 0; it < 6; it++) begin
      a_clear = '1; tick(); a_clear = '0;
      for (int c = 0; c < NA; c++) begin
        tg[c] = int'($urandom_range(0, 3));
        a_target = 32'(tg[c]);
        a_start = 4'(1 << c);
        tick();
      end
      a_start = '0;
      gen_traffic();
      for (int i = 0; i < L; i++) begin
        for (int c = 0; c < NA; c++) begin
          a_drv(c, tv[c][i], tr[c][i], tl[c][i], tk[c][i]);
          a_stop[c] = (i == sp[c]);
        end
        tick();
      end
      idle_all();
      tick();
      for (int c = 0; c < NA; c++) begin
        model(c);
        check_a($sformatf("rand it%0d ch%0d", it, c), c, m_cyc, m_beats, m_pkts, m_bytes,
                m_stalls, m_err, 3, 0);
      end
    end

    // Asynchronous reset in the middle of running windows
    a_clear = '1; tick(); a_clear = '0;
    a_target = 32'd0; a_start = '1; tick(); a_start = '0;
    a_sel = 2'd1;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < NA; c++) a_drv(c, 1, ($urandom_range(0, 1) == 1), 0, ONES);
      tick();
    end
    chk("rst pre active", 64'(a_active), 64'hF);
    #2 rst = 1'b1;
    #1;
    chk("rst cycles",  64'(a_cyc),    64'd0);
    chk("rst beats",   64'(a_beats),  64'd0);
    chk("rst bytes",   64'(a_bytes),  64'd0);
    chk("rst stalls",  64'(a_stalls), 64'd0);
    chk("rst state",   64'(a_state),  64'd0);
    chk("rst active",  64'(a_active), 64'd0);
    chk("rst done",    64'(a_done),   64'd0);
    idle_all();
    #1 rst = 1'b0;
    check_a("post rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
